// File: rtl/frog_pkg.sv
// Shared types and helpers for the frog key conditioner: direction indices,
// debouncer states and the fixed-priority grant function.
package frog_pkg;

    localparam int unsigned NUM_DIRS = 4;

    typedef enum logic [1:0] {
        DIR_R = 2'd0,
        DIR_L = 2'd1,
        DIR_D = 2'd2,
        DIR_U = 2'd3
    } dir_e;

    typedef enum logic [1:0] {
        RELEASED,
        ARMING,
        PRESSED,
        DISARMING
    } deb_state_e;

    function automatic int unsigned cnt_width(int unsigned a, int unsigned b, int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

    // Highest set index wins, which gives u > d > l > r with the dir_e encoding.
    function automatic logic [NUM_DIRS-1:0] prio_grant(logic [NUM_DIRS-1:0] req);
        logic [NUM_DIRS-1:0] g;
        g = '0;
        for (int i = 0; i < NUM_DIRS; i++) begin
            if (req[i]) begin
                g    = '0;
                g[i] = 1'b1;
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// One direction key: 2-flop synchroniser, press/release debounce FSM and an
// optional hold-to-repeat timer. fire pulses once per accepted press or repeat.
module key_debounce
    import frog_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned KEY_ACTIVE_LOW  = 1,
    parameter int unsigned REPEAT_EN       = 0,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_PERIOD   = 10000000
) (
    input  logic clock,
    input  logic reset,
    input  logic key,
    output logic fire,
    output logic held
);

    localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
    localparam logic IDLE_LVL = (KEY_ACTIVE_LOW != 0);
    // cnt already holds the samples seen so far, so the current one is the last when cnt == N-1.
    localparam logic [CW-1:0] DEB_LAST       = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] RPT_FIRST_LAST = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] RPT_NEXT_LAST  = CW'(REPEAT_PERIOD - 1);

    logic [1:0]    sync_q;
    logic          s;
    deb_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] rpt_q, rpt_d;
    logic          rpt_seq_q, rpt_seq_d;

    function automatic logic [CW-1:0] sat_inc(logic [CW-1:0] x);
        return (x == {CW{1'b1}}) ? x : x + CW'(1);
    endfunction

    assign s    = sync_q[1] ^ IDLE_LVL;
    assign held = (state_q == PRESSED) || (state_q == DISARMING);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rpt_d     = rpt_q;
        rpt_seq_d = rpt_seq_q;
        fire      = 1'b0;
        unique case (state_q)
            RELEASED: begin
                rpt_d     = '0;
                rpt_seq_d = 1'b0;
                if (s) begin
                    state_d = ARMING;
                    cnt_d   = CW'(1);
                end
            end
            ARMING: begin
                if (!s) begin
                    state_d = RELEASED;
                end else if (cnt_q == DEB_LAST) begin
                    state_d   = PRESSED;
                    fire      = 1'b1;
                    rpt_d     = '0;
                    rpt_seq_d = 1'b0;
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end
            PRESSED: begin
                if (!s) begin
                    state_d = DISARMING;
                    cnt_d   = CW'(1);
                end else if (REPEAT_EN != 0) begin
                    // First repeat waits REPEAT_DELAY, later ones REPEAT_PERIOD.
                    if (rpt_q >= (rpt_seq_q ? RPT_NEXT_LAST : RPT_FIRST_LAST)) begin
                        fire      = 1'b1;
                        rpt_d     = '0;
                        rpt_seq_d = 1'b1;
                    end else begin
                        rpt_d = sat_inc(rpt_q);
                    end
                end
            end
            DISARMING: begin
                if (s) begin
                    state_d = PRESSED;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = RELEASED;
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end
            default: state_d = RELEASED;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_q    <= {2{IDLE_LVL}};
            state_q   <= RELEASED;
            cnt_q     <= '0;
            rpt_q     <= '0;
            rpt_seq_q <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], key};
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rpt_q     <= rpt_d;
            rpt_seq_q <= rpt_seq_d;
        end
    end

endmodule

// File: rtl/frog_key_conditioner.sv
// Four debounced direction keys feeding a pending register and a fixed-priority
// arbiter that issues at most one registered move pulse per cycle.
module frog_key_conditioner
    import frog_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned KEY_ACTIVE_LOW  = 1,
    parameter int unsigned REPEAT_EN       = 0,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_PERIOD   = 10000000
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                key_l,
    input  logic                key_d,
    input  logic                key_u,
    input  logic                key_r,
    input  logic                enable,
    output logic                l,
    output logic                d,
    output logic                u,
    output logic                r,
    output logic [NUM_DIRS-1:0] held
);

    logic [NUM_DIRS-1:0] keys;
    logic [NUM_DIRS-1:0] fire;
    logic [NUM_DIRS-1:0] pending_q, pending_d;
    logic [NUM_DIRS-1:0] grant;
    logic [NUM_DIRS-1:0] dir_q, dir_d;

    assign keys = {key_u, key_d, key_l, key_r};

    for (genvar i = 0; i < NUM_DIRS; i++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .KEY_ACTIVE_LOW (KEY_ACTIVE_LOW),
            .REPEAT_EN      (REPEAT_EN),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD)
        ) u_key_debounce (
            .clock(clock),
            .reset(reset),
            .key  (keys[i]),
            .fire (fire[i]),
            .held (held[i])
        );
    end

    always_comb begin
        // Masking the direction just issued keeps any output from staying high two cycles.
        grant     = prio_grant(pending_q & ~dir_q);
        dir_d     = enable ? grant : '0;
        pending_d = enable ? ((pending_q & ~grant) | fire) : '0;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pending_q <= '0;
            dir_q     <= '0;
        end else begin
            pending_q <= pending_d;
            dir_q     <= dir_d;
        end
    end

    assign r = dir_q[DIR_R];
    assign l = dir_q[DIR_L];
    assign d = dir_q[DIR_D];
    assign u = dir_q[DIR_U];

endmodule
